// File: rtl/lfsr_r24_chk.sv
// Receive-side checker for the R24 parallel-LFSR PRBS stream: self-seeds from the
// incoming data, locks after a run of correct predictions, then counts word and bit errors.
module lfsr_r24_chk #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dv_i,
  input  logic [23:0]      data_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             err_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_err_cnt_o
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      SUM_W   = ((CNT_W > 5) ? CNT_W : 5) + 1;

  function automatic logic [23:0] lfsr_next(input logic [23:0] s);
    logic [23:0] n;
    n    = '0;
    n[0] = s[10] ^ s[17] ^ s[20] ^ s[23] ^ s[0];
    n[1] = s[11] ^ s[17] ^ s[18] ^ s[21] ^ s[22] ^ s[23] ^ s[0] ^ s[1];
    for (int i = 2; i <= 6; i++)
      n[i] = s[i+10] ^ s[i+15] ^ s[i+16] ^ s[i+17] ^ s[i-2] ^ s[i-1] ^ s[i];
    for (int i = 7; i <= 23; i++)
      n[i] = s[i-7] ^ s[i-2] ^ s[i-1] ^ s[i];
    return n;
  endfunction

  function automatic logic [4:0] popcount24(input logic [23:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 24; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [23:0]      exp_q, exp_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic [7:0]       mmcnt_q, mmcnt_d;
  logic             err_q;
  logic [CNT_W-1:0] word_cnt_q, err_cnt_q, bit_err_cnt_q;

  logic [23:0]      seed_next, exp_next;
  logic [8:0]       mcnt_inc, mmcnt_inc;
  logic             mism;
  logic [4:0]       diff_bits;
  logic             word_ev, err_ev;
  logic [SUM_W-1:0] bit_sum;
  logic [CNT_W-1:0] bit_sat;

  assign seed_next = lfsr_next(data_i);
  assign exp_next  = lfsr_next(exp_q);
  assign mism      = (data_i != exp_q);
  assign diff_bits = popcount24(data_i ^ exp_q);
  assign mcnt_inc  = {1'b0, mcnt_q} + 9'd1;
  assign mmcnt_inc = {1'b0, mmcnt_q} + 9'd1;
  assign bit_sum   = SUM_W'(bit_err_cnt_q) + SUM_W'(diff_bits);
  assign bit_sat   = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];

  // NOTE: every register here shares the async reset; none of this is a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
      exp_q   <= '0;
      mcnt_q  <= '0;
      mmcnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      state_q <= state_d;
      exp_q   <= exp_d;
      mcnt_q  <= mcnt_d;
      mmcnt_q <= mmcnt_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mcnt_d  = mcnt_q;
    mmcnt_d = mmcnt_q;
    word_ev = 1'b0;
    err_ev  = 1'b0;
    if (dv_i) begin
      case (state_q)
        ST_SEARCH: begin
          if (data_i != '0) begin
            exp_d   = seed_next;
            mcnt_d  = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (!mism) begin
            exp_d  = exp_next;
            mcnt_d = mcnt_inc[7:0];
            if (mcnt_inc == 9'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              mmcnt_d = '0;
            end
          end else if (data_i != '0) begin
            // A broken prediction reseeds from the offending word, exactly like SEARCH.
            exp_d  = seed_next;
            mcnt_d = '0;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          exp_d   = exp_next;
          word_ev = 1'b1;
          if (mism) begin
            err_ev  = 1'b1;
            mmcnt_d = mmcnt_inc[7:0];
            if (mmcnt_inc == 9'(UNLOCK_CNT)) state_d = ST_SEARCH;
          end else begin
            mmcnt_d = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // CLR wins over a same-cycle event; the ERR pulse is independent of CLR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q         <= 1'b0;
      word_cnt_q    <= '0;
      err_cnt_q     <= '0;
      bit_err_cnt_q <= '0;
    end else begin
      err_q <= err_ev;
      if (clr_i) begin
        word_cnt_q    <= '0;
        err_cnt_q     <= '0;
        bit_err_cnt_q <= '0;
      end else begin
        if (word_ev && word_cnt_q != CNT_MAX) word_cnt_q <= word_cnt_q + CNT_W'(1);
        if (err_ev && err_cnt_q != CNT_MAX)   err_cnt_q  <= err_cnt_q + CNT_W'(1);
        if (err_ev)                           bit_err_cnt_q <= bit_sat;
      end
    end
  end

  always_comb begin
    lock_o        = (state_q == ST_LOCKED);
    err_o         = err_q;
    word_cnt_o    = word_cnt_q;
    err_cnt_o     = err_cnt_q;
    bit_err_cnt_o = bit_err_cnt_q;
  end

endmodule

// File: tb/tb_lfsr_r24_chk.sv
// Randomized and directed bench for lfsr_r24_chk; a behavioural model tracks lock and counts.
module tb_lfsr_r24_chk;

  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv_i;
  logic [23:0] data_i;
  logic        clr_i;

  logic        lock_a, err_a, lock_b, err_b;
  logic [31:0] wc_a, ec_a, bc_a;
  logic [3:0]  wc_b, ec_b, bc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_r24_chk #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .dv_i(dv_i), .data_i(data_i), .clr_i(clr_i),
    .lock_o(lock_a), .err_o(err_a), .word_cnt_o(wc_a), .err_cnt_o(ec_a),
    .bit_err_cnt_o(bc_a)
  );

  lfsr_r24_chk #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .dv_i(dv_i), .data_i(data_i), .clr_i(clr_i),
    .lock_o(lock_b), .err_o(err_b), .word_cnt_o(wc_b), .err_cnt_o(ec_b),
    .bit_err_cnt_o(bc_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference sequence: each output bit is the XOR of the listed taps of the previous word.
  function automatic logic [23:0] prbs_f(input logic [23:0] s);
    logic [23:0] n;
    for (int i = 0; i < 24; i++) begin
      if (i == 0)      n[i] = ^{s[10], s[17], s[20], s[23], s[0]};
      else if (i == 1) n[i] = ^{s[11], s[17], s[18], s[21], s[22], s[23], s[0], s[1]};
      else if (i <= 6) n[i] = ^{s[i+10], s[i+15], s[i+16], s[i+17], s[i-2], s[i-1], s[i]};
      else             n[i] = ^{s[i-7], s[i-2], s[i-1], s[i]};
    end
    return n;
  endfunction

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Behavioural model: mode 0 = hunting for a seed, 1 = counting good predictions, 2 = locked.
  int          m_mode;
  logic [23:0] m_pred;
  int          m_good, m_bad;
  longint      m_words, m_errs, m_bits;
  logic        m_err;

  task automatic model_reset();
    m_mode = 0; m_pred = '0; m_good = 0; m_bad = 0;
    m_words = 0; m_errs = 0; m_bits = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic dv, input logic [23:0] d, input logic clr);
    logic w, e;
    int   b;
    w = 1'b0; e = 1'b0; b = 0;
    if (dv) begin
      if (m_mode == 2) begin
        w = 1'b1;
        if (d != m_pred) begin
          e = 1'b1;
          b = $countones(d ^ m_pred);
          m_bad++;
        end else begin
          m_bad = 0;
        end
        m_pred = prbs_f(m_pred);
        if (m_bad == UNLOCK_CNT) m_mode = 0;
      end else if (m_mode == 1 && d == m_pred) begin
        m_pred = prbs_f(m_pred);
        m_good++;
        if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
      end else if (d != 0) begin
        m_pred = prbs_f(d); m_good = 0; m_mode = 1;
      end else begin
        m_mode = 0;
      end
    end
    m_err = e;
    if (clr) begin
      m_words = 0; m_errs = 0; m_bits = 0;
    end else begin
      m_words += longint'(w);
      m_errs  += longint'(e);
      m_bits  += b;
    end
  endtask

  task automatic compare_all();
    check("lock",      {63'd0, lock_a}, {63'd0, m_mode == 2});
    check("err",       {63'd0, err_a},  {63'd0, m_err});
    check("word_cnt",  64'(wc_a), sat(m_words, 32));
    check("err_cnt",   64'(ec_a), sat(m_errs, 32));
    check("bit_cnt",   64'(bc_a), sat(m_bits, 32));
    check("lock4",     {63'd0, lock_b}, {63'd0, m_mode == 2});
    check("err4",      {63'd0, err_b},  {63'd0, m_err});
    check("word_cnt4", 64'(wc_b), sat(m_words, 4));
    check("err_cnt4",  64'(ec_b), sat(m_errs, 4));
    check("bit_cnt4",  64'(bc_b), sat(m_bits, 4));
  endtask

  // Called at a falling edge; drives for one cycle and checks after the next rising edge.
  task automatic step(input logic dv, input logic [23:0] d, input logic clr);
    dv_i = dv; data_i = d; clr_i = clr;
    model_step(dv, d, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dv_i = 1'b0; data_i = '0; clr_i = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  logic [23:0] gen;

  task automatic clean_word();
    gen = prbs_f(gen);
    step(1'b1, gen, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [23:0] bad;
    int          gap;

    rst_n = 1'b0; dv_i = 1'b0; data_i = '0; clr_i = 1'b0;

    // Clean stream from the reference seed: lock after word 9, then 91 counted words.
    do_reset();
    gen = 24'h4DB62E;
    for (int k = 1; k <= 100; k++) begin
      clean_word();
      if (k == LOCK_CNT)     check("lock_before_w9", {63'd0, lock_a}, 64'd0);
      if (k == LOCK_CNT + 1) check("lock_at_w9", {63'd0, lock_a}, 64'd1);
    end
    check("t1_words", 64'(wc_a), 64'd91);
    check("t1_errs",  64'(ec_a), 64'd0);

    // Single flipped bit while locked.
    gen = prbs_f(gen);
    step(1'b1, gen ^ 24'h000020, 1'b0);
    check("t2_err_pulse", {63'd0, err_a}, 64'd1);
    check("t2_err_cnt",   64'(ec_a), 64'd1);
    check("t2_bit_cnt",   64'(bc_a), 64'd1);
    check("t2_lock",      {63'd0, lock_a}, 64'd1);
    clean_word();
    check("t2_err_clear", {63'd0, err_a}, 64'd0);

    // Clear, then four fully inverted words drop lock; a clean stream relocks after 9 words.
    gen = prbs_f(gen);
    step(1'b1, gen, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      gen = prbs_f(gen);
      step(1'b1, gen ^ 24'hFFFFFF, 1'b0);
      if (k == 3) check("t3_lock_held", {63'd0, lock_a}, 64'd1);
    end
    check("t3_err_cnt", 64'(ec_a), 64'd4);
    check("t3_bit_cnt", 64'(bc_a), 64'd96);
    check("t3_unlock",  {63'd0, lock_a}, 64'd0);
    for (int k = 1; k <= 9; k++) begin
      clean_word();
      if (k == 8) check("t3_relock_early", {63'd0, lock_a}, 64'd0);
    end
    check("t3_relock", {63'd0, lock_a}, 64'd1);

    // All-zero data never seeds; first nonzero word starts verification.
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 24'h0, 1'b0);
    check("t4_no_lock", {63'd0, lock_a}, 64'd0);
    gen = 24'h000001;
    for (int k = 1; k <= 9; k++) clean_word();
    check("t4_lock", {63'd0, lock_a}, 64'd1);

    // Mismatch in verification at word 5 reseeds; random DV gaps do not count as words.
    do_reset();
    gen = 24'hA5C3F1;
    for (int k = 1; k <= 4; k++) clean_word();
    bad = prbs_f(gen) ^ 24'h000003;
    if (bad == 0) bad = 24'h800000;
    gen = bad;
    step(1'b1, bad, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step(1'b0, 24'($urandom), 1'b0);
      if (k == 8) check("t5_lock_early", {63'd0, lock_a}, 64'd0);
      clean_word();
    end
    check("t5_lock", {63'd0, lock_a}, 64'd1);

    // Saturation of the narrow counters, CLR against a same-cycle error, async reset.
    do_reset();
    gen = 24'h13579B;
    for (int k = 1; k <= 9; k++) clean_word();
    for (int k = 0; k < 20; k++) begin
      gen = prbs_f(gen);
      step(1'b1, gen ^ (24'h1 << $urandom_range(0, 23)), 1'b0);
      clean_word();
    end
    check("t6_err_sat4", 64'(ec_b), 64'd15);
    check("t6_bit_sat4", 64'(bc_b), 64'd15);
    check("t6_err_cnt",  64'(ec_a), 64'd20);
    gen = prbs_f(gen);
    step(1'b1, gen ^ 24'h000100, 1'b1);
    check("t6_clr_err",  {63'd0, err_a}, 64'd1);
    check("t6_clr_cnt",  64'(ec_a), 64'd0);
    check("t6_clr_word", 64'(wc_a), 64'd0);
    dv_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("t6_async_lock", {63'd0, lock_a}, 64'd0);
    check("t6_async_err", {63'd0, err_a}, 64'd0);
    do_reset();

    // Randomized stream: occasional corruption, zero words, jumps, DV gaps and clears.
    gen = 24'($urandom_range(1, 24'hFFFFFF));
    for (int k = 0; k < 2000; k++) begin
      int r;
      logic [23:0] d;
      logic        dv;
      r  = $urandom_range(0, 99);
      dv = ($urandom_range(0, 9) < 8);
      if (dv) gen = prbs_f(gen);
      d = gen;
      if (r < 5)       d = gen ^ 24'($urandom_range(1, 24'hFFFFFF));
      else if (r < 6)  d = gen ^ 24'hFFFFFF;
      else if (r < 7)  d = 24'h0;
      else if (r == 7 && dv) begin
        gen = 24'($urandom_range(1, 24'hFFFFFF));
        d = gen;
      end
      step(dv, dv ? d : 24'($urandom), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
